// File: rtl/sram_bank_arbiter_if.sv
// Requester/bank signal bundle for sram_bank_arbiter.
// The arbiter uses the slave modport; requesters plus bank wrapper sit on the master modport.
interface sram_bank_arbiter_if #(
   parameter int N_REQ = 2,
   parameter int AW    = 11,
   parameter int DW    = 128
);
   localparam int BW = DW / 8;

   // Handshake: req_i[k] is a valid; gnt_o[k] is the ready, combinational in the same cycle.
   // A transfer happens on a cycle with req_i[k] && gnt_o[k]. The requester holds we/addr/wdata/be
   // stable from req rise until that cycle. rvalid_o[k] follows the transfer by exactly one cycle
   // (reads and writes) with no back-pressure; rdata_o is meaningful only for a read response.
   logic [N_REQ-1:0]      req_i;
   logic [N_REQ-1:0]      we_i;
   logic [N_REQ*AW-1:0]   addr_i;
   logic [N_REQ*DW-1:0]   wdata_i;
   logic [N_REQ*BW-1:0]   be_i;
   logic [N_REQ-1:0]      gnt_o;
   logic [N_REQ-1:0]      rvalid_o;
   logic [DW-1:0]         rdata_o;
   logic                  mem_en_o;
   logic                  mem_we_o;
   logic [AW-1:0]         mem_addr_o;
   logic [DW-1:0]         mem_wdata_o;
   logic [BW-1:0]         mem_be_o;
   logic [DW-1:0]         mem_rdata_i;
   logic                  init_done_o;
   logic                  dbg_state_o;

   modport slave (
      input  req_i, we_i, addr_i, wdata_i, be_i, mem_rdata_i,
      output gnt_o, rvalid_o, rdata_o, mem_en_o, mem_we_o, mem_addr_o,
             mem_wdata_o, mem_be_o, init_done_o, dbg_state_o
   );

   modport master (
      output req_i, we_i, addr_i, wdata_i, be_i, mem_rdata_i,
      input  gnt_o, rvalid_o, rdata_o, mem_en_o, mem_we_o, mem_addr_o,
             mem_wdata_o, mem_be_o, init_done_o, dbg_state_o
   );
endinterface

// File: rtl/sram_bank_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM bank between N_REQ OBI-style requesters.
// Optional zero-fill of the whole bank after reset is enabled by defining SRAM_ARB_INIT_EN.
module sram_bank_arbiter #(
   parameter int N_REQ = 2,
   parameter int AW    = 11,
   parameter int DW    = 128
) (
   input logic                clk,
   input logic                rst_n,
   sram_bank_arbiter_if.slave bus
);
   localparam int BW = DW / 8;
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   logic [PW-1:0]    r_rr_ptr;
   logic [N_REQ-1:0] r_rvalid;
   logic             w_arb_en;
   logic             w_found;
   logic [PW-1:0]    w_win;
   logic [PW:0]      w_idx;
   logic [N_REQ-1:0] w_gnt;
   logic             w_init_busy;
   logic [AW-1:0]    w_init_addr;
   logic             w_state_run;

`ifdef SRAM_ARB_INIT_EN
   state_t        r_state;
   logic [AW-1:0] r_init_cnt;
   logic          r_init_done;

   // init_done rises on the same edge that leaves INIT, i.e. the cycle after the last fill write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_INIT;
         r_init_cnt  <= '0;
         r_init_done <= 1'b0;
      end else begin
         case (r_state)
            ST_INIT: begin
               r_init_cnt <= r_init_cnt + 1'b1;
               if (r_init_cnt == {AW{1'b1}}) begin
                  r_state     <= ST_RUN;
                  r_init_done <= 1'b1;
               end
            end
            default: r_init_done <= 1'b1;
         endcase
      end
   end

   assign w_arb_en    = r_init_done;
   assign w_init_busy = !r_init_done;
   assign w_init_addr = r_init_cnt;
   assign w_state_run = (r_state == ST_RUN);
`else
   assign w_arb_en    = 1'b1;
   assign w_init_busy = 1'b0;
   assign w_init_addr = '0;
   assign w_state_run = (ST_RUN == ST_RUN);
`endif

   // Search order starts at the pointer and wraps; first active request wins.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_idx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_idx = {1'b0, r_rr_ptr} + (PW+1)'(i);
         if (w_idx >= (PW+1)'(N_REQ)) begin
            w_idx = w_idx - (PW+1)'(N_REQ);
         end
         if (!w_found && bus.req_i[w_idx[PW-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_idx[PW-1:0];
         end
      end
   end

   always_comb begin
      w_gnt = '0;
      if (w_arb_en && w_found) begin
         w_gnt[w_win] = 1'b1;
      end
   end

   always_comb begin
      bus.mem_en_o    = 1'b0;
      bus.mem_we_o    = 1'b0;
      bus.mem_addr_o  = '0;
      bus.mem_wdata_o = '0;
      bus.mem_be_o    = '0;
      if (w_init_busy) begin
         bus.mem_en_o   = 1'b1;
         bus.mem_we_o   = 1'b1;
         bus.mem_addr_o = w_init_addr;
         bus.mem_be_o   = {BW{1'b1}};
      end else begin
         for (int k = 0; k < N_REQ; k++) begin
            if (w_gnt[k]) begin
               bus.mem_en_o    = 1'b1;
               bus.mem_we_o    = bus.we_i[k];
               bus.mem_addr_o  = bus.addr_i[k*AW +: AW];
               bus.mem_wdata_o = bus.wdata_i[k*DW +: DW];
               bus.mem_be_o    = bus.be_i[k*BW +: BW];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr <= '0;
         r_rvalid <= '0;
      end else begin
         r_rvalid <= w_gnt;
         if (|w_gnt) begin
            r_rr_ptr <= (w_win == PW'(N_REQ - 1)) ? '0 : w_win + 1'b1;
         end
      end
   end

   assign bus.gnt_o       = w_gnt;
   assign bus.rvalid_o    = r_rvalid;
   assign bus.rdata_o     = bus.mem_rdata_i;
   assign bus.init_done_o = w_arb_en;
   assign bus.dbg_state_o = w_state_run;

   a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(w_gnt));
   a_rvalid_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_rvalid));
   a_no_gnt_in_init : assert property (@(posedge clk) disable iff (!rst_n) w_init_busy |-> (w_gnt == '0));
endmodule

// File: tb/tb_sram_bank_arbiter.sv
// Self-checking bench for sram_bank_arbiter with a bank model, reference memory and per-requester response queues.
// Also covers the zero-fill path when SRAM_ARB_INIT_EN is defined.
module tb_sram_bank_arbiter;
   localparam int N_REQ = 2;
   localparam int AW    = 11;
   localparam int DW    = 128;
   localparam int BW    = DW / 8;
   localparam int DEPTH = 1 << AW;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   sram_bank_arbiter_if #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) bus ();

   sram_bank_arbiter #(.N_REQ(N_REQ), .AW(AW), .DW(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- requester drive ----------------
   logic          r0_req, r1_req, r0_we, r1_we;
   logic [AW-1:0] r0_addr, r1_addr;
   logic [DW-1:0] r0_wdata, r1_wdata;
   logic [BW-1:0] r0_be, r1_be;

   assign bus.req_i   = {r1_req, r0_req};
   assign bus.we_i    = {r1_we, r0_we};
   assign bus.addr_i  = {r1_addr, r0_addr};
   assign bus.wdata_i = {r1_wdata, r0_wdata};
   assign bus.be_i    = {r1_be, r0_be};

   // ---------------- bank model ----------------
   logic [DW-1:0] bank [0:DEPTH-1];
   logic [DW-1:0] bank_q;
   logic          do_preload;

   function automatic logic [DW-1:0] pat(input int i);
      logic [7:0] b;
      if (i == 5) return {16{8'hA5}};
      b = 8'(i * 7 + 3);
      return {16{b}};
   endfunction

   always @(posedge clk) begin
      if (do_preload) begin
         for (int i = 0; i < DEPTH; i++) bank[i] <= pat(i);
      end else if (bus.mem_en_o) begin
         if (bus.mem_we_o) begin
            for (int b = 0; b < BW; b++)
               if (bus.mem_be_o[b]) bank[bus.mem_addr_o][b*8 +: 8] <= bus.mem_wdata_o[b*8 +: 8];
         end else begin
            bank_q <= bank[bus.mem_addr_o];
         end
      end
   end
   assign bus.mem_rdata_i = bank_q;

   // ---------------- scoreboard ----------------
   logic [DW-1:0] ref_mem [0:DEPTH-1];
   logic [DW:0]   exp_q0[$];
   logic [DW:0]   exp_q1[$];
   int            grant_log[$];

   task automatic tb_check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // ---------------- monitor / reference arbiter ----------------
   int          m_rr;
   logic [1:0]  m_prev;
   int          m_icnt;
   logic        m_on;
   logic [1:0]  exp_g;
   int          win;
   logic [DW:0] e;

   always @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_rr   = 0;
         m_prev = '0;
         m_icnt = 0;
      end else begin
`ifdef SRAM_ARB_INIT_EN
         m_on = (m_icnt >= DEPTH);
`else
         m_on = 1'b1;
`endif
         tb_check("init_done", DW'(bus.init_done_o), DW'(m_on));
         tb_check("dbg_state", DW'(bus.dbg_state_o), DW'(m_on));
         tb_check("rvalid", DW'(bus.rvalid_o), DW'(m_prev));
         for (int k = 0; k < N_REQ; k++) begin
            if (m_prev[k]) begin
               if (k == 0) begin
                  tb_check("q0_nonempty", DW'(exp_q0.size() > 0), DW'(1));
                  e = (exp_q0.size() > 0) ? exp_q0.pop_front() : '0;
               end else begin
                  tb_check("q1_nonempty", DW'(exp_q1.size() > 0), DW'(1));
                  e = (exp_q1.size() > 0) ? exp_q1.pop_front() : '0;
               end
               if (e[DW]) tb_check($sformatf("rdata%0d", k), bus.rdata_o, e[DW-1:0]);
            end
         end
         exp_g = '0;
         if (!m_on) begin
            tb_check("init_gnt", DW'(bus.gnt_o), '0);
            tb_check("init_en", DW'(bus.mem_en_o), DW'(1));
            tb_check("init_we", DW'(bus.mem_we_o), DW'(1));
            tb_check("init_addr", DW'(bus.mem_addr_o), DW'(m_icnt[AW-1:0]));
            tb_check("init_be", DW'(bus.mem_be_o), DW'(16'hFFFF));
            tb_check("init_wdata", bus.mem_wdata_o, '0);
            m_icnt++;
         end else begin
            win = -1;
            for (int i = 0; i < N_REQ; i++)
               if (win < 0 && bus.req_i[(m_rr + i) % N_REQ]) win = (m_rr + i) % N_REQ;
            if (win >= 0) exp_g[win] = 1'b1;
            tb_check("gnt", DW'(bus.gnt_o), DW'(exp_g));
            tb_check("mem_en", DW'(bus.mem_en_o), DW'(win >= 0));
            if (win >= 0) begin
               grant_log.push_back(win);
               tb_check("mem_addr", DW'(bus.mem_addr_o), DW'(bus.addr_i[win*AW +: AW]));
               tb_check("mem_we", DW'(bus.mem_we_o), DW'(bus.we_i[win]));
               if (bus.we_i[win]) begin
                  tb_check("mem_be", DW'(bus.mem_be_o), DW'(bus.be_i[win*BW +: BW]));
                  tb_check("mem_wdata", bus.mem_wdata_o, bus.wdata_i[win*DW +: DW]);
               end
               m_rr = (win + 1) % N_REQ;
            end
         end
         m_prev = exp_g;
      end
   end

   // ---------------- driver ----------------
   task automatic issue(input int k, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [BW-1:0] be, output int waited);
      bit granted;
      if (w) begin
         for (int b = 0; b < BW; b++) if (be[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
         if (k == 0) exp_q0.push_back({1'b0, {DW{1'b0}}}); else exp_q1.push_back({1'b0, {DW{1'b0}}});
      end else begin
         if (k == 0) exp_q0.push_back({1'b1, ref_mem[a]}); else exp_q1.push_back({1'b1, ref_mem[a]});
      end
      if (k == 0) begin
         r0_req = 1'b1; r0_we = w; r0_addr = a; r0_wdata = d; r0_be = be;
      end else begin
         r1_req = 1'b1; r1_we = w; r1_addr = a; r1_wdata = d; r1_be = be;
      end
      waited  = 0;
      granted = 1'b0;
      for (int n = 0; n < 5000; n++) begin
         @(negedge clk);
         if (bus.gnt_o[k]) begin
            granted = 1'b1;
            break;
         end
         waited++;
      end
      tb_check($sformatf("gnt_wait%0d", k), DW'(granted), DW'(1));
      @(posedge clk);
      #1;
      if (k == 0) r0_req = 1'b0; else r1_req = 1'b0;
   endtask

   task automatic rand_ops(input int k, input int n);
      int wt;
      for (int i = 0; i < n; i++) begin
         issue(k, 1'($urandom_range(0, 1)), AW'(k * 1024 + $urandom_range(0, 1023)),
               {$urandom(), $urandom(), $urandom(), $urandom()}, BW'($urandom()), wt);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
   endtask

   // ---------------- main sequence ----------------
   int  wt0, wt1;
   bit  hit;

   initial begin
      n_checks = 0; n_fail = 0;
      rst_n = 1'b0; do_preload = 1'b1;
      r0_req = 0; r1_req = 0; r0_we = 0; r1_we = 0;
      r0_addr = '0; r1_addr = '0; r0_wdata = '0; r1_wdata = '0; r0_be = '0; r1_be = '0;
      for (int i = 0; i < DEPTH; i++) begin
`ifdef SRAM_ARB_INIT_EN
         ref_mem[i] = '0;
`else
         ref_mem[i] = pat(i);
`endif
      end
      repeat (3) @(posedge clk);
      #1;
      do_preload = 1'b0;
      rst_n = 1'b1;

      @(negedge clk);
      tb_check("rst_rvalid", DW'(bus.rvalid_o), '0);
      tb_check("rst_gnt", DW'(bus.gnt_o), '0);
`ifdef SRAM_ARB_INIT_EN
      tb_check("rst_init_done", DW'(bus.init_done_o), '0);
      // Interrupt the fill halfway, then hold req0 through the restarted fill.
      hit = 1'b0;
      for (int n = 0; n < 1100; n++) begin
         if (bus.mem_en_o && bus.mem_addr_o == AW'(11'h400)) begin
            hit = 1'b1;
            break;
         end
         @(negedge clk);
      end
      tb_check("init_reach_400", DW'(hit), DW'(1));
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      issue(0, 1'b0, AW'(5), '0, '0, wt0);
      tb_check("init_wait_cycles", DW'(wt0), DW'(2048));
`else
      tb_check("rst_init_done", DW'(bus.init_done_o), DW'(1));
      tb_check("rst_mem_en", DW'(bus.mem_en_o), '0);
      @(posedge clk);
      #1;
`endif

      // Single read of a preloaded word; granted in the first cycle.
      issue(0, 1'b0, AW'(5), '0, '0, wt0);
      tb_check("single_wait", DW'(wt0), '0);

      // Partial write at the top address, then read it back.
      issue(1, 1'b1, AW'(11'h7FF), 128'h0123456789ABCDEF_FEDCBA98765432FF, 16'h0001, wt1);
      issue(1, 1'b0, AW'(11'h7FF), '0, '0, wt1);
      tb_check("bw_refmem", ref_mem[11'h7FF][7:0] == 8'hFF ? DW'(1) : '0, DW'(1));

      // Contention with the pointer at 0: expected grants 0,1,0,1.
      grant_log.delete();
      fork
         begin
            issue(0, 1'b0, AW'(16), '0, '0, wt0);
            issue(0, 1'b0, AW'(17), '0, '0, wt0);
         end
         begin
            issue(1, 1'b0, AW'(1040), '0, '0, wt1);
            tb_check("stall_wait1", DW'(wt1), DW'(1));
            issue(1, 1'b0, AW'(1041), '0, '0, wt1);
         end
      join
      tb_check("cont_len", DW'(grant_log.size()), DW'(4));
      if (grant_log.size() == 4) begin
         tb_check("cont_g0", DW'(grant_log[0]), DW'(0));
         tb_check("cont_g1", DW'(grant_log[1]), DW'(1));
         tb_check("cont_g2", DW'(grant_log[2]), DW'(0));
         tb_check("cont_g3", DW'(grant_log[3]), DW'(1));
      end

      // Random traffic, disjoint address halves per requester.
      fork
         rand_ops(0, 25);
         rand_ops(1, 25);
      join
      repeat (3) @(posedge clk);
      #1;
      tb_check("q0_drained", DW'(exp_q0.size()), '0);
      tb_check("q1_drained", DW'(exp_q1.size()), '0);

      // Reset while a read is in flight: its response must never appear.
      r0_req = 1'b1; r0_we = 1'b0; r0_addr = AW'(3);
      @(negedge clk);
      tb_check("abort_gnt", DW'(bus.gnt_o), DW'(1));
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      r0_req = 1'b0;
      #1;
      tb_check("abort_rvalid", DW'(bus.rvalid_o), '0);
      exp_q0.delete();
      exp_q1.delete();
`ifdef SRAM_ARB_INIT_EN
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      issue(1, 1'b0, AW'(3), '0, '0, wt1);
      repeat (3) @(posedge clk);
      #1;
      tb_check("final_q1", DW'(exp_q1.size()), '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end
endmodule
